level_to_set_reset: RTL

//  Inverse of the set/reset trigger: turns a raw level into registered set/reset pulses.

---
 rtl/level_to_set_reset.sv | 97 +++++++++
 1 files changed

// File: rtl/level_to_set_reset.sv
// level_to_set_reset
// Turns a raw input level into a debounced, registered level plus one-clock
// set/reset pulses on each qualified rising/falling change.
// Optional feature macro: LEVEL_TO_SR_SYNC_EN adds a 2-FF input synchronizer
// (reset to INIT_LEVEL) in front of the qualifier, adding two clocks of latency.
module level_to_set_reset #(
  parameter int DEB_CYCLES = 4,
  parameter bit INIT_LEVEL = 1'b0,
  parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic s,
  output logic r,
  output logic q,
  output logic nq,
  output logic busy
);

  // A qualification window of zero clocks has no meaning; refuse to elaborate.
  generate
    if (DEB_CYCLES < 1) begin : gBadDebCycles
      $error("level_to_set_reset: DEB_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             setPulse_q;
  logic             rstPulse_q;
  logic             dSampled;

`ifdef LEVEL_TO_SR_SYNC_EN
  logic syncMeta_q;
  logic syncOut_q;

  // Two-stage synchronizer so d may be asynchronous to clk.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      syncMeta_q <= INIT_LEVEL;
      syncOut_q  <= INIT_LEVEL;
    end else begin
      syncMeta_q <= d;
      syncOut_q  <= syncMeta_q;
    end
  end

  assign dSampled = syncOut_q;
`else
  assign dSampled = d;
`endif

  // Debounce FSM: count consecutive mismatching samples, commit on the last one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= STABLE;
      cnt_q      <= '0;
      level_q    <= INIT_LEVEL;
      setPulse_q <= 1'b0;
      rstPulse_q <= 1'b0;
    end else begin
      setPulse_q <= 1'b0;
      rstPulse_q <= 1'b0;
      if (dSampled == level_q) begin
        // Any matching sample throws away a partial qualification (glitch).
        state_q <= STABLE;
        cnt_q   <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // Commit: after this edge level_q matches dSampled, so pulses last one clock.
        state_q    <= STABLE;
        cnt_q      <= '0;
        level_q    <= dSampled;
        setPulse_q <= dSampled;
        rstPulse_q <= ~dSampled;
      end else begin
        state_q <= QUALIFY;
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign s    = setPulse_q;
  assign r    = rstPulse_q;
  assign q    = level_q;
  assign nq   = ~level_q;
  assign busy = (state_q == QUALIFY);

endmodule
